// File: rtl/muladd_sched_pkg.sv
// -----------------------------------------------------------------------------
// muladd_sched_pkg
// Shared definitions for the shared multiply-add scheduler:
//   - reset defaults for the per-requester scale/offset slots
//   - output-register FSM state encoding
//   - helper deriving the result width from the operand width
// -----------------------------------------------------------------------------
package muladd_sched_pkg;

    // Values loaded into every scale/offset slot on reset
    localparam int DEF_SCALE  = 4;
    localparam int DEF_OFFSET = 3;

    // Output register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Result width is always two bits wider than the operand width
    function automatic int out_width(input int width);
        return width + 2;
    endfunction

endpackage : muladd_sched_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Scans req starting at rr_ptr and moving
// upward modulo NUM_REQ; the first asserted bit wins. The pointer register
// itself lives in the parent.
// Ports:
//   req     - per-requester request vector
//   rr_ptr  - index where the scan starts
//   enable  - when low, no grant is issued
//   gnt     - one-hot grant
//   gnt_idx - encoded index of the granted requester (0 when none)
//   gnt_any - a grant is being issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    // Rotating priority scan: first requester at or above rr_ptr (wrapping) wins
    always_comb begin
        int cand_s;
        gnt     = {NUM_REQ{1'b0}};
        gnt_idx = {ID_W{1'b0}};
        gnt_any = 1'b0;
        cand_s  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // rr_ptr never exceeds NUM_REQ-1, so one subtraction wraps it
            cand_s = int'(rr_ptr) + i;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            if (enable && !gnt_any && req[cand_s]) begin
                gnt[cand_s] = 1'b1;
                gnt_idx     = ID_W'(cand_s);
                gnt_any     = 1'b1;
            end else begin
                gnt_any = gnt_any;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/shared_muladd_sched.sv
// -----------------------------------------------------------------------------
// shared_muladd_sched
// One registered multiply-add unit, res = a*scale + offset (mod 2^OUT_WIDTH),
// shared round-robin among NUM_REQ requesters. Each requester owns a
// scale/offset slot written through the config port. A single output register
// feeds a consumer that may stall; with res_ready held high one result is
// produced per cycle.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   req, req_a                     - requests and flattened operands
//                                    (slot i = req_a[i*WIDTH +: WIDTH])
//   gnt                            - one-hot accept strobe (combinational)
//   cfg_we, cfg_sel,
//   cfg_scale, cfg_offset          - per-slot coefficient write port
//   res_valid, res_ready,
//   res_id, res_data               - result handshake and payload
//   busy                           - result held or any request pending
// -----------------------------------------------------------------------------
module shared_muladd_sched
    import muladd_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 4,
    parameter int OUT_WIDTH  = muladd_sched_pkg::out_width(WIDTH),
    parameter int DEF_SCALE  = muladd_sched_pkg::DEF_SCALE,
    parameter int DEF_OFFSET = muladd_sched_pkg::DEF_OFFSET,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    output logic [NUM_REQ-1:0]       gnt,
    input  logic                     cfg_we,
    input  logic [ID_W-1:0]          cfg_sel,
    input  logic [WIDTH-1:0]         cfg_scale,
    input  logic [WIDTH-1:0]         cfg_offset,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ID_W-1:0]          res_id,
    output logic [OUT_WIDTH-1:0]     res_data,
    output logic                     busy
);

    localparam int EXT_W = OUT_WIDTH - WIDTH;

    state_t               state_r;
    state_t               state_next_s;
    logic [ID_W-1:0]      rr_ptr_r;
    logic [ID_W-1:0]      ptr_next_s;
    logic [WIDTH-1:0]     scale_r  [NUM_REQ];
    logic [WIDTH-1:0]     offset_r [NUM_REQ];
    logic [WIDTH-1:0]     a_arr_s  [NUM_REQ];

    logic                 stall_s;
    logic                 arb_en_s;
    logic                 accept_s;
    logic [ID_W-1:0]      gnt_idx_s;
    logic [OUT_WIDTH-1:0] a_ext_s;
    logic [OUT_WIDTH-1:0] scale_ext_s;
    logic [OUT_WIDTH-1:0] offset_ext_s;
    logic [OUT_WIDTH-1:0] res_next_s;
    logic [31:0]          cfg_sel_ext_s;

    // Unpack the flattened operand bus into per-requester slots
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr_s[g] = req_a[g*WIDTH +: WIDTH];
    end

    // No grants while the held result is stalled or during the reset cycle
    assign stall_s  = (state_r == ST_FULL) && !res_ready;
    assign arb_en_s = !stall_s && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr_r),
        .enable  (arb_en_s),
        .gnt     (gnt),
        .gnt_idx (gnt_idx_s),
        .gnt_any (accept_s)
    );

    // Zero-extend operands to the result width; the product and the sum both
    // wrap naturally at OUT_WIDTH bits, so no saturation logic is needed.
    // Coefficients are read from the slot registers before any same-cycle
    // config write lands, so such a write only affects later accepts.
    always_comb begin
        a_ext_s      = {{EXT_W{1'b0}}, a_arr_s[gnt_idx_s]};
        scale_ext_s  = {{EXT_W{1'b0}}, scale_r[gnt_idx_s]};
        offset_ext_s = {{EXT_W{1'b0}}, offset_r[gnt_idx_s]};
        res_next_s   = (a_ext_s * scale_ext_s) + offset_ext_s;
    end

    // Pointer moves to the slot after the accepted one, wrapping to zero
    always_comb begin
        ptr_next_s = rr_ptr_r;
        if (gnt_idx_s == ID_W'(NUM_REQ - 1)) begin
            ptr_next_s = {ID_W{1'b0}};
        end else begin
            ptr_next_s = gnt_idx_s + {{(ID_W-1){1'b0}}, 1'b1};
        end
    end

    // Output register occupancy: an accept always (re)fills it; it drains
    // only when the consumer takes the result and nothing new is accepted
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (!res_ready) begin
                    state_next_s = ST_FULL;
                end else if (accept_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // FSM state, round-robin pointer and result payload registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_EMPTY;
            rr_ptr_r <= {ID_W{1'b0}};
            res_id   <= {ID_W{1'b0}};
            res_data <= {OUT_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                rr_ptr_r <= ptr_next_s;
                res_id   <= gnt_idx_s;
                res_data <= res_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
                res_id   <= res_id;
                res_data <= res_data;
            end
        end
    end

    assign cfg_sel_ext_s = 32'(cfg_sel);

    // Per-requester coefficient slots; out-of-range selects are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                scale_r[i]  <= WIDTH'(DEF_SCALE);
                offset_r[i] <= WIDTH'(DEF_OFFSET);
            end
        end else if (cfg_we && (cfg_sel_ext_s < 32'(NUM_REQ))) begin
            scale_r[cfg_sel]  <= cfg_scale;
            offset_r[cfg_sel] <= cfg_offset;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                scale_r[i]  <= scale_r[i];
                offset_r[i] <= offset_r[i];
            end
        end
    end

    assign res_valid = (state_r == ST_FULL);
    assign busy      = res_valid || (|req);

endmodule : shared_muladd_sched
